// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the load/store memory ports
package mem_pkg;
    localparam int XLEN_BYTES = 8;
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_D  = 3'b011,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101,
        SZ_WU = 3'b110,
        SZ_X  = 3'b111
    } mem_size_e;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} dmem_state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering, strobes, load extension and misalignment check
module lsu_align
    import mem_pkg::*;
#(
    parameter int XLEN = 8 * XLEN_BYTES
) (
    input  logic [2:0]                  funct3,
    input  logic [$clog2(XLEN/8)-1:0]   offset,
    input  logic [XLEN-1:0]             wdata,
    input  logic [XLEN-1:0]             rdata,
    output logic [XLEN-1:0]             lane_wdata,
    output logic [XLEN/8-1:0]           strb,
    output logic [XLEN-1:0]             load_data,
    output logic                        misaligned
);
    localparam int OW = $clog2(XLEN/8);
    logic [3:0] nb;
    logic [XLEN-1:0] shifted;
    logic sgn;
    assign nb = 4'd1 << funct3[1:0];
    assign sgn = !funct3[2];
    assign misaligned = (funct3 == SZ_X) || (|(offset & OW'(nb - 4'd1)));
    assign strb = ~({(XLEN/8){1'b1}} << nb) << offset;
    assign lane_wdata = wdata << {offset, 3'b000};
    assign shifted = rdata >> {offset, 3'b000};
    assign load_data = funct3[1:0] == 2'd0 ? {{(XLEN-8){sgn & shifted[7]}}, shifted[7:0]} :
                       funct3[1:0] == 2'd1 ? {{(XLEN-16){sgn & shifted[15]}}, shifted[15:0]} :
                       funct3[1:0] == 2'd2 ? {{(XLEN-32){sgn & shifted[31]}}, shifted[31:0]} :
                       shifted;
endmodule

// File: rtl/data_mem_port.sv
// data_mem_port: MEM-stage data bus responder, one bus transaction per load/store
module data_mem_port
    import mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_mem_valid,
    input  logic                ex_mem_mem_read,
    input  logic                ex_mem_mem_write,
    input  logic [2:0]          ex_mem_funct3,
    input  logic [XLEN-1:0]     ex_mem_addr,
    input  logic [XLEN-1:0]     ex_mem_wdata,
    input  logic                ex_mem_enable,
    input  logic                flush,
    output logic                read_done,
    output logic                write_done,
    output logic [XLEN-1:0]     load_data,
    output logic                misaligned,
    output logic                dbus_req_valid,
    input  logic                dbus_req_ready,
    output logic                dbus_req_write,
    output logic [XLEN-1:0]     dbus_req_addr,
    output logic [XLEN-1:0]     dbus_req_wdata,
    output logic [XLEN/8-1:0]   dbus_req_strb,
    input  logic                dbus_resp_valid,
    input  logic [XLEN-1:0]     dbus_resp_rdata
);
    localparam int OW = $clog2(XLEN/8);
    dmem_state_e state, state_next;
    logic op_write, mis_q, idle, go, mis;
    logic [2:0] f3_q;
    logic [XLEN-1:0] addr_q, wdata_q, lane_wdata, extracted;
    logic [XLEN/8-1:0] strb_q, strb;
    assign idle = state == IDLE;
    assign go = ex_mem_valid && (ex_mem_mem_read || ex_mem_mem_write) && !flush;
    // Steering uses the live EX/MEM fields in IDLE, extraction uses the latched ones afterwards
    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (idle ? ex_mem_funct3 : f3_q),
        .offset     (idle ? ex_mem_addr[OW-1:0] : addr_q[OW-1:0]),
        .wdata      (ex_mem_wdata),
        .rdata      (dbus_resp_rdata),
        .lane_wdata (lane_wdata),
        .strb       (strb),
        .load_data  (extracted),
        .misaligned (mis)
    );
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = go ? (mis ? DONE : REQ) : IDLE;
            REQ:     state_next = flush ? (dbus_req_ready ? DRAIN : IDLE) : (dbus_req_ready ? WAIT : REQ);
            WAIT:    state_next = dbus_resp_valid ? (flush ? IDLE : DONE) : (flush ? DRAIN : WAIT);
            DONE:    state_next = (flush || ex_mem_enable) ? IDLE : DONE;
            DRAIN:   state_next = dbus_resp_valid ? IDLE : DRAIN;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_write  <= 1'b0;
            mis_q     <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            load_data <= '0;
        end else begin
            state <= state_next;
            if (idle && go) begin
                op_write <= ex_mem_mem_write && !ex_mem_mem_read;
                mis_q    <= mis;
                f3_q     <= ex_mem_funct3;
                addr_q   <= ex_mem_addr;
                wdata_q  <= lane_wdata;
                strb_q   <= strb;
            end
            if (state == WAIT && dbus_resp_valid && !flush) load_data <= extracted;
        end
    end
    assign dbus_req_valid = state == REQ;
    assign dbus_req_write = op_write;
    assign dbus_req_addr  = {addr_q[XLEN-1:OW], OW'(0)};
    assign dbus_req_wdata = wdata_q;
    assign dbus_req_strb  = strb_q;
    assign read_done      = state == DONE && !op_write;
    assign write_done     = state == DONE && op_write;
    assign misaligned     = state == DONE && mis_q;
endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: vector table, directed corner sequences and random ops against a byte-level model
module tb_data_mem_port;
    import mem_pkg::*;
    logic clk = 0, reset = 1;
    logic ex_mem_valid = 0, ex_mem_mem_read = 0, ex_mem_mem_write = 0, ex_mem_enable = 0, flush = 0;
    logic [2:0] ex_mem_funct3 = 0;
    logic [63:0] ex_mem_addr = 0, ex_mem_wdata = 0, dbus_resp_rdata = 0;
    logic [63:0] load_data, dbus_req_addr, dbus_req_wdata;
    logic read_done, write_done, misaligned, dbus_req_valid, dbus_req_write;
    logic dbus_req_ready = 0, dbus_resp_valid = 0;
    logic [7:0] dbus_req_strb;
    int n_chk = 0, n_err = 0;
    logic [63:0] bmem [0:8191];
    logic [7:0] rmem [0:65535];

    typedef struct {
        logic rd, wr, mis, stable, held, idle, wr_req;
        int lat, nreq;
        logic [63:0] load, addr, wdata;
        logic [7:0] strb;
    } res_t;

    typedef struct {
        logic rd, wr;
        logic [2:0] f3;
        logic [63:0] addr, wdata, pre;
        int rdy, en;
        logic e_mis;
        int e_lat;
        logic [63:0] e_load, e_addr, e_wdata;
        logic [7:0] e_strb;
    } vec_t;

    always #5 clk = ~clk;

    data_mem_port #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .ex_mem_valid(ex_mem_valid), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
        .ex_mem_funct3(ex_mem_funct3), .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
        .ex_mem_enable(ex_mem_enable), .flush(flush),
        .read_done(read_done), .write_done(write_done), .load_data(load_data), .misaligned(misaligned),
        .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready), .dbus_req_write(dbus_req_write),
        .dbus_req_addr(dbus_req_addr), .dbus_req_wdata(dbus_req_wdata), .dbus_req_strb(dbus_req_strb),
        .dbus_resp_valid(dbus_resp_valid), .dbus_resp_rdata(dbus_resp_rdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [63:0] a);
        return f3 == 3'b111 || (int'(a[2:0]) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] a);
        logic [63:0] v = 0;
        int n = nbytes(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[a[15:0] + 16'(i)];
        if (!f3[2] && n < 8 && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] m_strb(input logic [2:0] f3, input logic [63:0] a);
        logic [7:0] s = 0;
        for (int i = 0; i < nbytes(f3); i++) if (int'(a[2:0]) + i < 8) s[int'(a[2:0]) + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_lane(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        logic [63:0] v = 0;
        for (int i = 0; i < nbytes(f3); i++) if (int'(a[2:0]) + i < 8) v[8*(int'(a[2:0]) + i) +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    function automatic logic [63:0] lmask(input logic [7:0] s);
        logic [63:0] m = 0;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        for (int i = 0; i < nbytes(f3); i++) rmem[a[15:0] + 16'(i)] = wd[8*i +: 8];
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] w);
        bmem[a[15:3]] = w;
        for (int i = 0; i < 8; i++) rmem[{a[15:3], 3'(i)}] = w[8*i +: 8];
    endtask

    // Presents one op, plays the bus with the given ready delay, then holds enable low for en cycles
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input int rdy, input int en, output res_t r);
        logic held = 0, resp_next = 0, done = 0;
        int waitc = 0, cyc = 0;
        logic [63:0] s_addr = 0, s_wdata = 0;
        logic [7:0] s_strb = 0;
        logic s_wr = 0;
        r = '{default: 0};
        r.lat = -1;
        r.stable = 1;
        r.held = 1;
        ex_mem_valid = 1; ex_mem_mem_read = rd; ex_mem_mem_write = wr;
        ex_mem_funct3 = f3; ex_mem_addr = a; ex_mem_wdata = wd; ex_mem_enable = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
            dbus_req_ready = 0;
            dbus_resp_valid = resp_next;
            dbus_resp_rdata = resp_next ? bmem[s_addr[15:3]] : {$urandom, $urandom};
            resp_next = 0;
            if (read_done || write_done) begin
                done = 1; r.lat = cyc; r.rd = read_done; r.wr = write_done;
                r.mis = misaligned; r.load = load_data;
            end else if (dbus_req_valid) begin
                if (held && {dbus_req_addr, dbus_req_wdata, dbus_req_strb, dbus_req_write} != {s_addr, s_wdata, s_strb, s_wr})
                    r.stable = 0;
                s_addr = dbus_req_addr; s_wdata = dbus_req_wdata; s_strb = dbus_req_strb; s_wr = dbus_req_write;
                held = 1;
                if (waitc >= rdy) begin
                    dbus_req_ready = 1; r.nreq++; held = 0; waitc = 0; resp_next = 1;
                    r.addr = s_addr; r.wdata = s_wdata; r.strb = s_strb; r.wr_req = s_wr;
                    if (s_wr) for (int i = 0; i < 8; i++) if (s_strb[i]) bmem[s_addr[15:3]][8*i +: 8] = s_wdata[8*i +: 8];
                end else waitc++;
            end
        end
        dbus_resp_valid = 0;
        dbus_req_ready = 0;
        for (int k = 0; k < en; k++) begin
            tick();
            if (read_done !== r.rd || write_done !== r.wr || dbus_req_valid) r.held = 0;
        end
        ex_mem_enable = 1;
        tick();
        ex_mem_enable = 0; ex_mem_valid = 0; ex_mem_mem_read = 0; ex_mem_mem_write = 0;
        r.idle = !read_done && !write_done && !dbus_req_valid;
    endtask

    task automatic check_res(input string tg, input res_t r, input logic rd, input logic e_mis, input int e_lat,
                             input logic [63:0] e_load, input logic [63:0] e_addr, input logic [63:0] e_wd,
                             input logic [7:0] e_strb);
        chk({tg, " latency"}, 64'(r.lat), 64'(e_lat));
        chk({tg, " done kind"}, {62'b0, r.rd, r.wr}, {62'b0, rd, !rd});
        chk({tg, " misaligned"}, 64'(r.mis), 64'(e_mis));
        chk({tg, " requests"}, 64'(r.nreq), e_mis ? 64'd0 : 64'd1);
        chk({tg, " hold/idle/stable"}, {61'b0, r.held, r.idle, r.stable}, 64'd7);
        if (rd && !e_mis) chk({tg, " load_data"}, r.load, e_load);
        if (!e_mis) begin
            chk({tg, " req addr"}, r.addr, e_addr);
            chk({tg, " req strb"}, 64'(r.strb), 64'(e_strb));
            chk({tg, " req write"}, 64'(r.wr_req), 64'(!rd));
            if (!rd) chk({tg, " req wdata"}, r.wdata & lmask(e_strb), e_wd);
        end
    endtask

    initial begin
        vec_t vt [13];
        res_t r;
        logic seen;
        logic [63:0] prev;
        vt = '{
            '{1, 0, 3'd2, 64'h1004, 64'h0, 64'h8000_0001_0000_0000, 0, 0, 0, 3, 64'hFFFF_FFFF_8000_0001, 64'h1000, 64'h0, 8'hF0},
            '{0, 1, 3'd0, 64'h2003, 64'hAB, 64'h0, 0, 0, 0, 3, 64'h0, 64'h2000, 64'h0000_0000_AB00_0000, 8'h08},
            '{1, 0, 3'd1, 64'h3001, 64'h0, 64'h0, 0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 8'h00},
            '{1, 0, 3'd3, 64'h1000, 64'h0, 64'h0, 5, 3, 0, 8, 64'h8000_0001_0000_0000, 64'h1000, 64'h0, 8'hFF},
            '{1, 0, 3'd0, 64'h1007, 64'h0, 64'h0, 0, 0, 0, 3, 64'hFFFF_FFFF_FFFF_FF80, 64'h1000, 64'h0, 8'h80},
            '{1, 0, 3'd5, 64'h1006, 64'h0, 64'h0, 1, 1, 0, 4, 64'h0000_0000_0000_8000, 64'h1000, 64'h0, 8'hC0},
            '{0, 1, 3'd3, 64'h5008, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 0, 0, 5, 64'h0, 64'h5008, 64'h0123_4567_89AB_CDEF, 8'hFF},
            '{1, 0, 3'd6, 64'h1004, 64'h0, 64'h0, 0, 0, 0, 3, 64'h0000_0000_8000_0001, 64'h1000, 64'h0, 8'hF0},
            '{1, 0, 3'd7, 64'h1000, 64'h0, 64'h0, 0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 8'h00},
            '{0, 1, 3'd2, 64'h2002, 64'h1234, 64'h0, 0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 8'h00},
            '{1, 1, 3'd2, 64'h1004, 64'h5555, 64'h0, 0, 0, 0, 3, 64'hFFFF_FFFF_8000_0001, 64'h1000, 64'h0, 8'hF0},
            '{1, 0, 3'd3, 64'h5008, 64'h0, 64'h0, 0, 0, 0, 3, 64'h0123_4567_89AB_CDEF, 64'h5008, 64'h0, 8'hFF},
            '{0, 1, 3'd1, 64'h2006, 64'hBEEF, 64'h0, 1, 2, 0, 4, 64'h0, 64'h2000, 64'hBEEF_0000_0000_0000, 8'hC0}
        };
        for (int i = 0; i < 8192; i++) preload(64'(i * 8), {$urandom, $urandom});
        tick();
        tick();
        chk("reset flags", {58'b0, read_done, write_done, misaligned, dbus_req_valid, dbus_req_write, 1'b0}, 64'd0);
        chk("reset load_data", load_data, 64'd0);
        chk("reset req fields", dbus_req_addr | dbus_req_wdata | 64'(dbus_req_strb), 64'd0);
        reset = 0;
        tick();

        foreach (vt[i]) begin
            if (vt[i].pre != 0) preload(vt[i].addr, vt[i].pre);
            run_op(vt[i].rd, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].rdy, vt[i].en, r);
            check_res($sformatf("vec%0d", i), r, vt[i].rd, vt[i].e_mis, vt[i].e_lat,
                      vt[i].e_load, vt[i].e_addr, vt[i].e_wdata, vt[i].e_strb);
            if (!vt[i].rd && !vt[i].e_mis) m_store(vt[i].f3, vt[i].addr, vt[i].wdata);
        end

        // Flush while waiting for a load response: response is drained, no done, data untouched
        preload(64'h4000, 64'h0011_2233_4455_6677);
        prev = load_data;
        ex_mem_valid = 1; ex_mem_mem_read = 1; ex_mem_funct3 = 3'd4; ex_mem_addr = 64'h4005;
        tick();
        chk("drain req issued", 64'(dbus_req_valid), 64'd1);
        dbus_req_ready = 1;
        tick();
        dbus_req_ready = 0; flush = 1;
        seen = read_done | write_done | dbus_req_valid;
        tick();
        flush = 0; ex_mem_valid = 0; ex_mem_mem_read = 0;
        dbus_resp_valid = 1; dbus_resp_rdata = bmem[64'h4000 >> 3];
        seen |= read_done | write_done | dbus_req_valid;
        tick();
        dbus_resp_valid = 0;
        for (int k = 0; k < 5; k++) begin
            seen |= read_done | write_done | dbus_req_valid;
            tick();
        end
        chk("drain no done", 64'(seen), 64'd0);
        chk("drain load_data kept", load_data, prev);
        run_op(1, 0, 3'd4, 64'h4005, 64'h0, 0, 0, r);
        check_res("after drain", r, 1, 0, 3, m_load(3'd4, 64'h4005), 64'h4000, 64'h0, m_strb(3'd4, 64'h4005));

        // Flush before the request is accepted drops it
        ex_mem_valid = 1; ex_mem_mem_read = 1; ex_mem_funct3 = 3'd2; ex_mem_addr = 64'h1004;
        tick();
        chk("req flush issued", 64'(dbus_req_valid), 64'd1);
        flush = 1;
        tick();
        flush = 0; ex_mem_valid = 0; ex_mem_mem_read = 0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            seen |= read_done | write_done | dbus_req_valid;
            tick();
        end
        chk("req flush dropped", 64'(seen), 64'd0);

        // Reset in WAIT abandons the transaction
        ex_mem_valid = 1; ex_mem_mem_read = 1; ex_mem_funct3 = 3'd3; ex_mem_addr = 64'h6000;
        tick();
        dbus_req_ready = 1;
        tick();
        dbus_req_ready = 0; reset = 1;
        tick();
        chk("wait reset flags", {58'b0, read_done, write_done, misaligned, dbus_req_valid, dbus_req_write, 1'b0}, 64'd0);
        chk("wait reset load_data", load_data, 64'd0);
        chk("wait reset req fields", dbus_req_addr | dbus_req_wdata | 64'(dbus_req_strb), 64'd0);
        reset = 0; ex_mem_valid = 0; ex_mem_mem_read = 0;
        tick();
        run_op(1, 0, 3'd3, 64'h6000, 64'h0, 1, 0, r);
        check_res("after reset", r, 1, 0, 4, m_load(3'd3, 64'h6000), 64'h6000, 64'h0, 8'hFF);

        for (int t = 0; t < 60; t++) begin
            int m, rdy, en;
            logic rd, wr, e_mis;
            logic [2:0] f3;
            logic [63:0] a, wd, e_load;
            m = $urandom_range(0, 2);
            rd = m != 1;
            wr = m != 0;
            f3 = rd ? 3'($urandom_range(0, 7)) : ($urandom_range(0, 5) == 0 ? 3'b111 : 3'($urandom_range(0, 3)));
            a = {32'h0, 16'($urandom), 16'($urandom)};
            if ($urandom_range(0, 3) != 0) a = a & ~64'(nbytes(f3) - 1);
            wd = {$urandom, $urandom};
            rdy = $urandom_range(0, 3);
            en = $urandom_range(0, 2);
            e_mis = m_mis(f3, a);
            e_load = m_load(f3, a);
            run_op(rd, wr, f3, a, wd, rdy, en, r);
            check_res($sformatf("rand%0d", t), r, rd, e_mis, e_mis ? 1 : 3 + rdy, e_load,
                      {a[63:3], 3'b000}, m_lane(f3, a, wd), m_strb(f3, a));
            if (!rd && !e_mis) m_store(f3, a, wd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
